// File: rtl/voice_allocator_if.sv
// Note-command handshake between a note source (master) and the voice allocator (slave).
interface voice_allocator_if;
   logic        note_valid;
   logic        note_ready;
   logic        note_on;
   logic [6:0]  note_key;
   logic [6:0]  note_velocity;
   logic [31:0] note_frequency;

   modport master (
      output note_valid, note_on, note_key, note_velocity, note_frequency,
      input  note_ready
   );

   modport slave (
      input  note_valid, note_on, note_key, note_velocity, note_frequency,
      output note_ready
   );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note commands to voice slots and runs a
// linear attack/release envelope per voice, stepped by a divided tick.
module voice_allocator #(
   parameter int unsigned NUM_VOICES = 8,
   parameter int unsigned TICK_DIV   = 1024
) (
   input  logic                clk,
   input  logic                reset,
   voice_allocator_if.slave    note,
   input  logic [19:0]         attack_rate,
   input  logic [19:0]         release_rate,
   output logic [31:0]         frequencies   [NUM_VOICES],
   output logic [31:0]         voice_volumes [NUM_VOICES],
   output logic [3:0]          active_count
);

   localparam int unsigned PW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned VW = 21;

   typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} vstate_t;

   vstate_t        state_q  [NUM_VOICES];
   vstate_t        state_d  [NUM_VOICES];
   logic [6:0]     key_q    [NUM_VOICES];
   logic [6:0]     key_d    [NUM_VOICES];
   logic [VW-1:0]  target_q [NUM_VOICES];
   logic [VW-1:0]  target_d [NUM_VOICES];
   logic [VW-1:0]  vol_q    [NUM_VOICES];
   logic [VW-1:0]  vol_d    [NUM_VOICES];
   logic [31:0]    freq_q   [NUM_VOICES];
   logic [31:0]    freq_d   [NUM_VOICES];

   logic [PW-1:0]  steal_q, steal_d;
   logic [CW-1:0]  tick_cnt_q;
   logic           tick_q;
   logic           ready_q;
   logic [3:0]     count_q, count_d;

   logic           accept;
   logic           is_on;
   logic           hit_f, idle_f, rel_f, steal;
   logic [PW-1:0]  hit_idx, idle_idx, rel_idx, sel_idx;
   logic [VW-1:0]  sum;

   assign note.note_ready = ready_q;
   assign accept          = note.note_valid && ready_q;
   assign is_on           = note.note_on && (note.note_velocity != 7'd0);
   assign active_count    = count_q;

   always_comb begin
      for (int v = 0; v < NUM_VOICES; v++) begin
         frequencies[v]   = freq_q[v];
         voice_volumes[v] = 32'(vol_q[v]);
      end
   end

   // Voice selection: retrigger, then lowest idle, then lowest releasing, then steal.
   always_comb begin
      hit_f    = 1'b0;
      idle_f   = 1'b0;
      rel_f    = 1'b0;
      hit_idx  = '0;
      idle_idx = '0;
      rel_idx  = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (!hit_f && (state_q[v] == ATTACK || state_q[v] == SUSTAIN) &&
             key_q[v] == note.note_key) begin
            hit_f   = 1'b1;
            hit_idx = PW'(v);
         end
         if (!idle_f && state_q[v] == IDLE) begin
            idle_f   = 1'b1;
            idle_idx = PW'(v);
         end
         if (!rel_f && state_q[v] == RELEASE) begin
            rel_f   = 1'b1;
            rel_idx = PW'(v);
         end
      end
      steal = !hit_f && !idle_f && !rel_f;
      if (hit_f)       sel_idx = hit_idx;
      else if (idle_f) sel_idx = idle_idx;
      else if (rel_f)  sel_idx = rel_idx;
      else             sel_idx = steal_q;
   end

   // Per-voice next state: a command wins over the envelope tick for its voice.
   always_comb begin
      steal_d = steal_q;
      count_d = 4'd0;
      sum     = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         state_d[v]  = state_q[v];
         key_d[v]    = key_q[v];
         target_d[v] = target_q[v];
         vol_d[v]    = vol_q[v];
         freq_d[v]   = freq_q[v];

         if (accept && is_on && PW'(v) == sel_idx) begin
            key_d[v]    = note.note_key;
            freq_d[v]   = note.note_frequency;
            target_d[v] = {1'b0, note.note_velocity, 13'd0};
            state_d[v]  = ATTACK;
            if (!hit_f) vol_d[v] = '0;
         end else if (accept && !is_on && key_q[v] == note.note_key &&
                      (state_q[v] == ATTACK || state_q[v] == SUSTAIN)) begin
            state_d[v] = RELEASE;
         end else if (tick_q) begin
            case (state_q[v])
               ATTACK: begin
                  sum = vol_q[v] + VW'(attack_rate);
                  if (sum >= target_q[v]) begin
                     vol_d[v]   = target_q[v];
                     state_d[v] = SUSTAIN;
                  end else begin
                     vol_d[v] = sum;
                  end
               end
               RELEASE: begin
                  if (vol_q[v] <= VW'(release_rate)) begin
                     vol_d[v]   = '0;
                     state_d[v] = IDLE;
                  end else begin
                     vol_d[v] = vol_q[v] - VW'(release_rate);
                  end
               end
               default: ;
            endcase
         end

         if (state_d[v] != IDLE) count_d = count_d + 4'd1;
      end

      if (accept && is_on && steal)
         steal_d = (steal_q == PW'(NUM_VOICES - 1)) ? '0 : steal_q + PW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            state_q[v]  <= IDLE;
            key_q[v]    <= '0;
            target_q[v] <= '0;
            vol_q[v]    <= '0;
            freq_q[v]   <= '0;
         end
         steal_q    <= '0;
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
         ready_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            state_q[v]  <= state_d[v];
            key_q[v]    <= key_d[v];
            target_q[v] <= target_d[v];
            vol_q[v]    <= vol_d[v];
            freq_q[v]   <= freq_d[v];
         end
         steal_q    <= steal_d;
         tick_cnt_q <= (tick_cnt_q == CW'(TICK_DIV - 1)) ? '0 : tick_cnt_q + CW'(1);
         tick_q     <= (tick_cnt_q == CW'(TICK_DIV - 1));
         ready_q    <= 1'b1;
         count_q    <= count_d;
      end
   end

endmodule
